// File: rtl/text_overlay_engine.sv
// Character-cell text overlay composited over an incoming pixel stream, double-buffered text RAM.
// Latency 4 clk from x/y/timing in to rgb/sync out; no backpressure, writes dropped while clearing.
module text_overlay_engine #(
    parameter int          COLS         = 32,
    parameter int          ROWS         = 8,
    parameter logic [9:0]  X0           = 10'd80,
    parameter logic [9:0]  Y0           = 10'd80,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter int          DOUBLE_BUF   = 1,
    parameter int          BLINK_FRAMES = 30,
    parameter int          AW           = $clog2(COLS*ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          video_on,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [11:0]   rgb_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          swap_req,
    output logic [10:0]   rom_addr,
    input  logic [7:0]    rom_data,
    output logic          busy,
    output logic          buf_sel,
    output logic [11:0]   rgb_out,
    output logic          video_on_out,
    output logic          hsync_out,
    output logic          vsync_out
);
    localparam int          CELLS = COLS * ROWS;
    localparam int          CW    = $clog2(CELLS);
    localparam int          BW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [10:0] XEND  = 11'(X0) + 11'(8 * COLS);
    localparam logic [10:0] YEND  = 11'(Y0) + 11'(16 * ROWS);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_sweep;
    logic            r_buf_sel, r_swap_pending, r_vs_prev, r_blink_phase;
    logic [BW-1:0]   r_blink_cnt;
    logic [7:0]      r_mem [0:1][0:(1<<CW)-1];

    logic            w_busy, w_vs_rise, w_wr_ok, w_wr_bank, w_in_win, w_pix;
    logic [9:0]      w_dx, w_dy;
    logic [CW-1:0]   w_cell;

    logic            r_s1_win, r_s1_von, r_s1_hs, r_s1_vs;
    logic [CW-1:0]   r_s1_cell;
    logic [3:0]      r_s1_row;
    logic [2:0]      r_s1_col;
    logic [11:0]     r_s1_rgb;
    logic            r_s2_win, r_s2_von, r_s2_hs, r_s2_vs;
    logic [7:0]      r_s2_char;
    logic [3:0]      r_s2_row;
    logic [2:0]      r_s2_col;
    logic [11:0]     r_s2_rgb;
    logic            r_s3_win, r_s3_blank, r_s3_von, r_s3_hs, r_s3_vs;
    logic [2:0]      r_s3_col;
    logic [11:0]     r_s3_rgb;

    assign w_busy    = (r_state == ST_CLEAR);
    assign w_vs_rise = vsync & ~r_vs_prev;
    assign w_wr_ok   = wr_en & ~w_busy & ~reset & (32'(wr_addr) < 32'(CELLS));
    // Back bank is sampled before any same-cycle swap, so a coincident write lands in the old back bank.
    assign w_wr_bank = (DOUBLE_BUF != 0) ? ~r_buf_sel : 1'b0;
    assign busy      = w_busy;
    assign buf_sel   = r_buf_sel;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_sweep == CW'(CELLS - 1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_CLEAR;
            r_sweep        <= '0;
            r_buf_sel      <= 1'b0;
            r_swap_pending <= 1'b0;
            r_vs_prev      <= 1'b0;
            r_blink_cnt    <= '0;
            r_blink_phase  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vs_prev <= vsync;
            if (w_busy) r_sweep <= r_sweep + CW'(1);
            if (w_vs_rise) begin
                if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
            if (w_vs_rise && r_swap_pending) begin
                r_swap_pending <= 1'b0;
                if (DOUBLE_BUF != 0) r_buf_sel <= ~r_buf_sel;
            end else if (swap_req && !w_busy) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[0][r_sweep] <= 8'h20;
            r_mem[1][r_sweep] <= 8'h20;
        end else if (w_wr_ok) begin
            r_mem[w_wr_bank][wr_addr[CW-1:0]] <= wr_data;
        end
    end

    assign w_dx     = x - X0;
    assign w_dy     = y - Y0;
    assign w_in_win = ({1'b0, x} >= {1'b0, X0}) && ({1'b0, x} < XEND) &&
                      ({1'b0, y} >= {1'b0, Y0}) && ({1'b0, y} < YEND);
    assign w_cell   = CW'(32'(w_dy[9:4]) * 32'(COLS) + 32'(w_dx[9:3]));
    assign rom_addr = {r_s2_char[6:0], r_s2_row};
    // Glyph bit 7 is the leftmost pixel, so the column index is inverted.
    assign w_pix    = rom_data[~r_s3_col];

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_s1_win, r_s1_von, r_s1_hs, r_s1_vs} <= '0;
            r_s1_cell <= '0; r_s1_row <= '0; r_s1_col <= '0; r_s1_rgb <= '0;
            {r_s2_win, r_s2_von, r_s2_hs, r_s2_vs} <= '0;
            r_s2_char <= '0; r_s2_row <= '0; r_s2_col <= '0; r_s2_rgb <= '0;
            {r_s3_win, r_s3_blank, r_s3_von, r_s3_hs, r_s3_vs} <= '0;
            r_s3_col <= '0; r_s3_rgb <= '0;
            rgb_out <= '0; video_on_out <= 1'b0; hsync_out <= 1'b0; vsync_out <= 1'b0;
        end else begin
            r_s1_win  <= w_in_win;
            r_s1_cell <= w_cell;
            r_s1_row  <= w_dy[3:0];
            r_s1_col  <= w_dx[2:0];
            r_s1_von  <= video_on;
            r_s1_hs   <= hsync;
            r_s1_vs   <= vsync;
            r_s1_rgb  <= rgb_in;

            r_s2_char <= r_mem[r_buf_sel][r_s1_cell];
            r_s2_win  <= r_s1_win;
            r_s2_row  <= r_s1_row;
            r_s2_col  <= r_s1_col;
            r_s2_von  <= r_s1_von;
            r_s2_hs   <= r_s1_hs;
            r_s2_vs   <= r_s1_vs;
            r_s2_rgb  <= r_s1_rgb;

            r_s3_win   <= r_s2_win;
            r_s3_blank <= r_s2_char[7] & r_blink_phase;
            r_s3_col   <= r_s2_col;
            r_s3_von   <= r_s2_von;
            r_s3_hs    <= r_s2_hs;
            r_s3_vs    <= r_s2_vs;
            r_s3_rgb   <= r_s2_rgb;

            if (!r_s3_von)                            rgb_out <= 12'h000;
            else if (r_s3_win && w_pix && !r_s3_blank) rgb_out <= FG_COLOR;
            else                                      rgb_out <= r_s3_rgb;
            video_on_out <= r_s3_von;
            hsync_out    <= r_s3_hs;
            vsync_out    <= r_s3_vs;
        end
    end
endmodule
